// File: rtl/dispatch_stage_n.sv
// N-wide in-order dispatch: per-slot decode, count-based admission, rename with
// intra-group bypass, registered RS/ROB allocation, halt FSM and dispatch counter.
package dispatch_pkg;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;
  localparam int AR_W  = 5;
  localparam logic [AR_W-1:0] ZERO_REG = '0;
  localparam logic [31:0]     WFI_INST = 32'h1050_0073;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_packet_t;

  typedef struct packed {
    logic             valid;
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [PR_W-1:0]  dest_pr;
    logic [PR_W-1:0]  reg1_pr;
    logic             reg1_ready;
    logic [PR_W-1:0]  reg2_pr;
    logic             reg2_ready;
    logic [ROB_W-1:0] rob_entry;
    logic             halt;
  } rs_in_packet_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    logic [AR_W-1:0] arch_reg;
    logic [PR_W-1:0] t_new;
    logic [PR_W-1:0] t_old;
    logic            halt;
  } rob_entry_packet_t;
endpackage

module dispatch_decoder
  import dispatch_pkg::*;
(
  input  logic            i_valid,
  input  logic [31:0]     i_inst,
  output logic [AR_W-1:0] o_dest,
  output logic [AR_W-1:0] o_rs1,
  output logic [AR_W-1:0] o_rs2,
  output logic            o_halt
);
  logic [6:0] w_opcode;
  assign w_opcode = i_inst[6:0];

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    o_dest = ZERO_REG;
    o_rs1  = ZERO_REG;
    o_rs2  = ZERO_REG;
    o_halt = 1'b0;
    if (i_valid) begin
      case (w_opcode)
        7'b0110111, 7'b0010111, 7'b1101111: o_dest = i_inst[11:7];
        7'b1100111, 7'b0000011, 7'b0010011: begin
          o_dest = i_inst[11:7];
          o_rs1  = i_inst[19:15];
        end
        7'b0110011: begin
          o_dest = i_inst[11:7];
          o_rs1  = i_inst[19:15];
          o_rs2  = i_inst[24:20];
        end
        7'b1100011, 7'b0100011: begin
          o_rs1 = i_inst[19:15];
          o_rs2 = i_inst[24:20];
        end
        7'b1110011: o_halt = (i_inst == WFI_INST);
        default: ;
      endcase
    end
  end
endmodule

module dispatch_stage_n
  import dispatch_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int CNT_W  = 4,
  parameter int PERF_W = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  if_id_packet_t                if_id_packet_in [WIDTH],
  output logic [$clog2(WIDTH+1)-1:0]   dis_num,
  input  logic [CNT_W-1:0]             rs_free_cnt,
  input  logic [CNT_W-1:0]             rob_free_cnt,
  input  logic [CNT_W-1:0]             free_reg_cnt,
  input  logic [PR_W-1:0]              free_pr_in [WIDTH],
  input  logic [ROB_W-1:0]             rob_index [WIDTH],
  output logic [WIDTH-1:0]             new_pr_en,
  output logic [AR_W-1:0]              maptable_ar [WIDTH],
  output logic [PR_W-1:0]              maptable_new_pr [WIDTH],
  input  logic [PR_W-1:0]              maptable_old_pr [WIDTH],
  output logic [AR_W-1:0]              reg1_ar [WIDTH],
  output logic [AR_W-1:0]              reg2_ar [WIDTH],
  input  logic [PR_W-1:0]              reg1_pr [WIDTH],
  input  logic [PR_W-1:0]              reg2_pr [WIDTH],
  input  logic [WIDTH-1:0]             reg1_ready,
  input  logic [WIDTH-1:0]             reg2_ready,
  output rs_in_packet_t                rs_in [WIDTH],
  output rob_entry_packet_t            rob_in [WIDTH],
  output logic                         halted,
  output logic [PERF_W-1:0]            dispatched_cnt
);
  localparam int NUM_W = $clog2(WIDTH + 1);

  typedef enum logic {S_RUN, S_HALTED} state_e;
  state_e r_state, w_state_next;

  logic [AR_W-1:0]   w_dest [WIDTH];
  logic [WIDTH-1:0]  w_halt, w_has_dest, w_acc, w_src1_rdy, w_src2_rdy;
  logic [PR_W-1:0]   w_new_pr [WIDTH];
  logic [PR_W-1:0]   w_src1_pr [WIDTH];
  logic [PR_W-1:0]   w_src2_pr [WIDTH];
  logic [PR_W-1:0]   w_told [WIDTH];
  logic [CNT_W-1:0]  w_pr_cnt, w_pr_need;
  logic              w_ok, w_take, w_halt_acc;
  rs_in_packet_t     w_rs_next [WIDTH];
  rob_entry_packet_t w_rob_next [WIDTH];
  rs_in_packet_t     r_rs_in [WIDTH];
  rob_entry_packet_t r_rob_in [WIDTH];
  logic [PERF_W-1:0] r_disp_cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_dec
    dispatch_decoder u_dec (
      .i_valid (if_id_packet_in[g].valid),
      .i_inst  (if_id_packet_in[g].inst),
      .o_dest  (w_dest[g]),
      .o_rs1   (reg1_ar[g]),
      .o_rs2   (reg2_ar[g]),
      .o_halt  (w_halt[g])
    );
    assign w_has_dest[g] = (w_dest[g] != ZERO_REG);
  end

  // Prefix admission; the k-th PR-consuming slot takes free-list head k.
  always_comb begin
    w_ok      = (r_state == S_RUN) && !squash;
    w_pr_cnt  = '0;
    w_pr_need = '0;
    w_take    = 1'b0;
    w_acc     = '0;
    dis_num   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pr_need = w_pr_cnt + CNT_W'(w_has_dest[i]);
      w_take    = w_ok && if_id_packet_in[i].valid &&
                  (CNT_W'(i + 1) <= rob_free_cnt) &&
                  (CNT_W'(i + 1) <= rs_free_cnt) &&
                  (w_pr_need <= free_reg_cnt);
      w_acc[i]    = w_take;
      w_new_pr[i] = '0;
      for (int k = 0; k < WIDTH; k++)
        if (CNT_W'(k) == w_pr_cnt) w_new_pr[i] = free_pr_in[k];
      if (w_take) begin
        w_pr_cnt = w_pr_need;
        dis_num  = NUM_W'(i + 1);
      end
      w_ok = w_take && !w_halt[i];
    end
    // Free-list pop mask: one bit per PR consumed, packed from bit 0.
    for (int k = 0; k < WIDTH; k++) new_pr_en[k] = (CNT_W'(k) < w_pr_cnt);
  end

  // Rename with bypass from older accepted slots; later matches overwrite, so youngest wins.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_src1_pr[i]  = reg1_pr[i];
      w_src1_rdy[i] = reg1_ready[i];
      w_src2_pr[i]  = reg2_pr[i];
      w_src2_rdy[i] = reg2_ready[i];
      w_told[i]     = maptable_old_pr[i];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && w_acc[j] && w_has_dest[j]) begin
          if (w_dest[j] == reg1_ar[i]) begin
            w_src1_pr[i]  = w_new_pr[j];
            w_src1_rdy[i] = 1'b0;
          end
          if (w_dest[j] == reg2_ar[i]) begin
            w_src2_pr[i]  = w_new_pr[j];
            w_src2_rdy[i] = 1'b0;
          end
          if (w_dest[j] == w_dest[i]) w_told[i] = w_new_pr[j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      maptable_ar[i]     = w_acc[i] ? w_dest[i] : ZERO_REG;
      maptable_new_pr[i] = (w_acc[i] && w_has_dest[i]) ? w_new_pr[i] : '0;
      w_rs_next[i]       = '0;
      w_rob_next[i]      = '0;
      if (w_acc[i]) begin
        w_rs_next[i].valid      = 1'b1;
        w_rs_next[i].pc         = if_id_packet_in[i].pc;
        w_rs_next[i].inst       = if_id_packet_in[i].inst;
        w_rs_next[i].dest_pr    = maptable_new_pr[i];
        w_rs_next[i].reg1_pr    = w_src1_pr[i];
        w_rs_next[i].reg1_ready = w_src1_rdy[i];
        w_rs_next[i].reg2_pr    = w_src2_pr[i];
        w_rs_next[i].reg2_ready = w_src2_rdy[i];
        w_rs_next[i].rob_entry  = rob_index[i];
        w_rs_next[i].halt       = w_halt[i];
        w_rob_next[i].valid     = 1'b1;
        w_rob_next[i].pc        = if_id_packet_in[i].pc;
        w_rob_next[i].arch_reg  = w_dest[i];
        w_rob_next[i].t_new     = maptable_new_pr[i];
        w_rob_next[i].t_old     = w_told[i];
        w_rob_next[i].halt      = w_halt[i];
      end
    end
  end

  assign w_halt_acc = |(w_acc & w_halt);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:     if (!squash && w_halt_acc) w_state_next = S_HALTED;
      S_HALTED:  if (squash) w_state_next = S_RUN;
      default:   w_state_next = S_RUN;
    endcase
  end

  // NOTE: non-blocking assignments so every flop here samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_RUN;
      r_disp_cnt <= '0;
      // NOTE: whole packets are cleared, not just valid, so the RS/ROB never see X payloads.
      for (int i = 0; i < WIDTH; i++) begin
        r_rs_in[i]  <= '0;
        r_rob_in[i] <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_disp_cnt <= r_disp_cnt + PERF_W'(dis_num);
      r_rs_in    <= w_rs_next;
      r_rob_in   <= w_rob_next;
    end
  end

  assign rs_in          = r_rs_in;
  assign rob_in         = r_rob_in;
  assign halted         = (r_state == S_HALTED);
  assign dispatched_cnt = r_disp_cnt;
endmodule

// File: tb/tb_dispatch_stage_n.sv
// Directed bench for dispatch_stage_n at WIDTH=3 with a 4-bit counter so wrap is exercised.
module tb_dispatch_stage_n;
  import dispatch_pkg::*;

  localparam int WIDTH  = 3;
  localparam int CNT_W  = 4;
  localparam int PERF_W = 4;

  logic                clock = 1'b0;
  logic                reset, squash;
  if_id_packet_t       pkt [WIDTH];
  logic [1:0]          dis_num;
  logic [CNT_W-1:0]    rs_free, rob_free, reg_free;
  logic [PR_W-1:0]     free_pr [WIDTH];
  logic [ROB_W-1:0]    rob_idx [WIDTH];
  logic [WIDTH-1:0]    new_pr_en;
  logic [AR_W-1:0]     mt_ar [WIDTH];
  logic [PR_W-1:0]     mt_new_pr [WIDTH];
  logic [PR_W-1:0]     mt_old_pr [WIDTH];
  logic [AR_W-1:0]     r1_ar [WIDTH];
  logic [AR_W-1:0]     r2_ar [WIDTH];
  logic [PR_W-1:0]     r1_pr [WIDTH];
  logic [PR_W-1:0]     r2_pr [WIDTH];
  logic [WIDTH-1:0]    r1_rdy, r2_rdy;
  rs_in_packet_t       rs_in [WIDTH];
  rob_entry_packet_t   rob_in [WIDTH];
  logic                halted;
  logic [PERF_W-1:0]   disp_cnt;

  dispatch_stage_n #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clock(clock), .reset(reset), .squash(squash), .if_id_packet_in(pkt),
    .dis_num(dis_num), .rs_free_cnt(rs_free), .rob_free_cnt(rob_free),
    .free_reg_cnt(reg_free), .free_pr_in(free_pr), .rob_index(rob_idx),
    .new_pr_en(new_pr_en), .maptable_ar(mt_ar), .maptable_new_pr(mt_new_pr),
    .maptable_old_pr(mt_old_pr), .reg1_ar(r1_ar), .reg2_ar(r2_ar),
    .reg1_pr(r1_pr), .reg2_pr(r2_pr), .reg1_ready(r1_rdy), .reg2_ready(r2_rdy),
    .rs_in(rs_in), .rob_in(rob_in), .halted(halted), .dispatched_cnt(disp_cnt)
  );

  always #5 clock = ~clock;

  int n_tests, n_fail;
  logic [PERF_W-1:0] exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1);
    return {12'd1, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction
  localparam logic [31:0] WFI = 32'h1050_0073;

  // Packed per-slot fields are written {slot2, slot1, slot0}.
  typedef struct packed {
    logic             rst, sq;
    logic [2:0]       v;
    logic [2:0][31:0] ins;
    logic [3:0]       rob, rs, pr;
    logic [2:0][5:0]  fpr, old;
    logic [1:0]       e_num;
    logic [2:0]       e_pr_en;
    logic [2:0][4:0]  e_ar;
    logic [2:0][5:0]  e_npr;
    logic [2:0]       e_rsv;
    logic [2:0][5:0]  e_r1;
    logic [2:0]       e_r1rdy;
    logic [2:0][5:0]  e_r2;
    logic [2:0]       e_r2rdy;
    logic [2:0][5:0]  e_told;
    logic [2:0]       e_hlt;
    logic             e_halted;
  } vec_t;

  function automatic vec_t base(input logic [2:0] v, input logic [31:0] i0, i1, i2);
    vec_t t;
    t = '0;
    t.v = v;
    t.ins[0] = i0; t.ins[1] = i1; t.ins[2] = i2;
    t.rob = 4'd8; t.rs = 4'd8; t.pr = 4'd8;
    t.fpr = {6'd12, 6'd11, 6'd10};
    t.old = {6'd22, 6'd21, 6'd20};
    return t;
  endfunction

  function automatic vec_t three_addi();
    vec_t t;
    t = base(3'b111, addi(1, 0), addi(2, 0), addi(3, 0));
    t.e_num = 2'd3; t.e_pr_en = 3'b111;
    t.e_ar  = {5'd3, 5'd2, 5'd1};
    t.e_npr = {6'd12, 6'd11, 6'd10};
    t.e_rsv = 3'b111;
    t.e_r1  = {6'd52, 6'd51, 6'd50}; t.e_r1rdy = 3'b111;
    t.e_r2  = {6'd58, 6'd57, 6'd56}; t.e_r2rdy = 3'b111;
    t.e_told = {6'd22, 6'd21, 6'd20};
    return t;
  endfunction

  // Registered-side expectations when only slot 0 is accepted (no bypass possible).
  function automatic vec_t slot0_only(input vec_t t_in);
    vec_t t;
    t = t_in;
    t.e_num = 2'd1; t.e_rsv = 3'b001;
    t.e_r1 = {6'd0, 6'd0, 6'd50}; t.e_r1rdy = 3'b001;
    t.e_r2 = {6'd0, 6'd0, 6'd56}; t.e_r2rdy = 3'b001;
    t.e_told = {6'd0, 6'd0, 6'd20};
    return t;
  endfunction

  task automatic drive(input vec_t t);
    reset = t.rst; squash = t.sq;
    rob_free = t.rob; rs_free = t.rs; reg_free = t.pr;
    for (int i = 0; i < WIDTH; i++) begin
      pkt[i].valid = t.v[i];
      pkt[i].inst  = t.ins[i];
      pkt[i].pc    = 32'h1000 + 32'(4 * i);
      free_pr[i]   = t.fpr[i];
      mt_old_pr[i] = t.old[i];
    end
  endtask

  task automatic run_vec(input string tag, input vec_t t);
    logic [2:0][4:0] a_ar, a_rbe, e_rbe;
    logic [2:0][5:0] a_npr, a_r1, a_r2, a_told, a_dpr;
    logic [2:0]      a_rsv, a_robv, a_r1rdy, a_r2rdy, a_hlt, a_rhlt;
    drive(t);
    @(negedge clock);
    for (int i = 0; i < WIDTH; i++) begin
      a_ar[i]  = mt_ar[i];
      a_npr[i] = mt_new_pr[i];
    end
    check($sformatf("%s dis_num", tag), 64'(dis_num), 64'(t.e_num));
    check($sformatf("%s new_pr_en", tag), 64'(new_pr_en), 64'(t.e_pr_en));
    check($sformatf("%s maptable_ar", tag), 64'(a_ar), 64'(t.e_ar));
    check($sformatf("%s maptable_new_pr", tag), 64'(a_npr), 64'(t.e_npr));
    @(posedge clock); #1;
    exp_cnt = t.rst ? '0 : exp_cnt + PERF_W'(t.e_num);
    for (int i = 0; i < WIDTH; i++) begin
      a_rsv[i] = rs_in[i].valid;      a_robv[i] = rob_in[i].valid;
      a_r1[i] = rs_in[i].reg1_pr;     a_r1rdy[i] = rs_in[i].reg1_ready;
      a_r2[i] = rs_in[i].reg2_pr;     a_r2rdy[i] = rs_in[i].reg2_ready;
      a_dpr[i] = rs_in[i].dest_pr;    a_told[i] = rob_in[i].t_old;
      a_hlt[i] = rs_in[i].halt;       a_rhlt[i] = rob_in[i].halt;
      a_rbe[i] = rs_in[i].rob_entry;
      e_rbe[i] = t.e_rsv[i] ? 5'(4 + i) : 5'd0;
    end
    check($sformatf("%s rs_valid", tag), 64'(a_rsv), 64'(t.e_rsv));
    check($sformatf("%s rob_valid", tag), 64'(a_robv), 64'(t.e_rsv));
    check($sformatf("%s reg1_pr", tag), 64'(a_r1), 64'(t.e_r1));
    check($sformatf("%s reg1_ready", tag), 64'(a_r1rdy), 64'(t.e_r1rdy));
    check($sformatf("%s reg2_pr", tag), 64'(a_r2), 64'(t.e_r2));
    check($sformatf("%s reg2_ready", tag), 64'(a_r2rdy), 64'(t.e_r2rdy));
    check($sformatf("%s dest_pr", tag), 64'(a_dpr), 64'(t.e_npr));
    check($sformatf("%s t_old", tag), 64'(a_told), 64'(t.e_told));
    check($sformatf("%s rob_entry", tag), 64'(a_rbe), 64'(e_rbe));
    check($sformatf("%s rs_halt", tag), 64'(a_hlt), 64'(t.e_hlt));
    check($sformatf("%s rob_halt", tag), 64'(a_rhlt), 64'(t.e_hlt));
    check($sformatf("%s halted", tag), 64'(halted), 64'(t.e_halted));
    check($sformatf("%s dispatched_cnt", tag), 64'(disp_cnt), 64'(exp_cnt));
  endtask

  vec_t vecs [8];
  vec_t t, v_halt;

  initial begin
    n_tests = 0; n_fail = 0; exp_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rob_idx[i] = 5'(4 + i);
      r1_pr[i]   = 6'(50 + i);
      r2_pr[i]   = 6'(56 + i);
    end
    r1_rdy = 3'b111; r2_rdy = 3'b111;

    // ---- table of single-cycle vectors ----
    vecs[0] = three_addi();

    t = slot0_only(three_addi());           // ROB limit of 1
    t.rob = 4'd1; t.e_pr_en = 3'b001;
    t.e_ar = {5'd0, 5'd0, 5'd1}; t.e_npr = {6'd0, 6'd0, 6'd10};
    vecs[1] = t;

    t = base(3'b111, add(5, 1, 2), add(6, 5, 5), addi(5, 5));   // intra-group bypass
    t.fpr = {6'd42, 6'd41, 6'd40}; t.old = {6'd32, 6'd31, 6'd30};
    t.e_num = 2'd3; t.e_pr_en = 3'b111;
    t.e_ar = {5'd5, 5'd6, 5'd5}; t.e_npr = {6'd42, 6'd41, 6'd40};
    t.e_rsv = 3'b111;
    t.e_r1 = {6'd40, 6'd40, 6'd50}; t.e_r1rdy = 3'b001;
    t.e_r2 = {6'd58, 6'd40, 6'd56}; t.e_r2rdy = 3'b101;
    t.e_told = {6'd40, 6'd31, 6'd30};
    vecs[2] = t;

    t = base(3'b111, sw(3, 4), addi(3, 0), addi(7, 0));    // PR index follows PR users, not slots
    t.pr = 4'd1; t.fpr = {6'd33, 6'd22, 6'd17}; t.old = {6'd3, 6'd2, 6'd1};
    t.e_num = 2'd2; t.e_pr_en = 3'b001;
    t.e_ar = {5'd0, 5'd3, 5'd0}; t.e_npr = {6'd0, 6'd17, 6'd0};
    t.e_rsv = 3'b011;
    t.e_r1 = {6'd0, 6'd51, 6'd50}; t.e_r1rdy = 3'b011;
    t.e_r2 = {6'd0, 6'd57, 6'd56}; t.e_r2rdy = 3'b011;
    t.e_told = {6'd0, 6'd2, 6'd1};
    vecs[3] = t;

    t = three_addi();                        // RS limit of 2
    t.rs = 4'd2; t.e_num = 2'd2; t.e_pr_en = 3'b011;
    t.e_ar = {5'd0, 5'd2, 5'd1}; t.e_npr = {6'd0, 6'd11, 6'd10};
    t.e_rsv = 3'b011;
    t.e_r1 = {6'd0, 6'd51, 6'd50}; t.e_r1rdy = 3'b011;
    t.e_r2 = {6'd0, 6'd57, 6'd56}; t.e_r2rdy = 3'b011;
    t.e_told = {6'd0, 6'd21, 6'd20};
    vecs[4] = t;

    t = slot0_only(three_addi());            // hole at slot 1 stops the prefix
    t.v = 3'b101; t.e_pr_en = 3'b001;
    t.e_ar = {5'd0, 5'd0, 5'd1}; t.e_npr = {6'd0, 6'd0, 6'd10};
    vecs[5] = t;

    t = slot0_only(base(3'b111, sw(3, 4), addi(3, 0), addi(7, 0)));  // no free PRs
    t.pr = 4'd0; t.e_pr_en = 3'b000;
    vecs[6] = t;

    vecs[7] = base(3'b000, addi(1, 0), addi(2, 0), addi(3, 0));      // nothing valid

    t = base(3'b000, 32'd0, 32'd0, 32'd0);
    t.rst = 1'b1;
    drive(t);
    repeat (2) @(posedge clock);
    #1;
    check("reset halted", 64'(halted), 64'd0);
    check("reset dispatched_cnt", 64'(disp_cnt), 64'd0);
    check("reset rs_valid", 64'({rs_in[2].valid, rs_in[1].valid, rs_in[0].valid}), 64'd0);
    check("reset rob_valid", 64'({rob_in[2].valid, rob_in[1].valid, rob_in[0].valid}), 64'd0);

    for (int n = 0; n < 8; n++) run_vec($sformatf("vec%0d", n), vecs[n]);

    // ---- halt, hold while halted, squash release, wrap of the 4-bit counter ----
    v_halt = base(3'b111, addi(1, 0), WFI, addi(2, 0));
    v_halt.e_num = 2'd2; v_halt.e_pr_en = 3'b001;
    v_halt.e_ar = {5'd0, 5'd0, 5'd1}; v_halt.e_npr = {6'd0, 6'd0, 6'd10};
    v_halt.e_rsv = 3'b011;
    v_halt.e_r1 = {6'd0, 6'd51, 6'd50}; v_halt.e_r1rdy = 3'b011;
    v_halt.e_r2 = {6'd0, 6'd57, 6'd56}; v_halt.e_r2rdy = 3'b011;
    v_halt.e_told = {6'd0, 6'd21, 6'd20};
    v_halt.e_hlt = 3'b010; v_halt.e_halted = 1'b1;
    run_vec("halt_accept", v_halt);

    t = base(3'b111, addi(1, 0), WFI, addi(2, 0));
    t.e_halted = 1'b1;
    run_vec("halted_hold", t);
    t.sq = 1'b1; t.e_halted = 1'b0;
    run_vec("halted_squash", t);
    run_vec("resume_wrap", three_addi());
    t = three_addi();
    t.sq = 1'b1;
    t.e_num = '0; t.e_pr_en = '0; t.e_ar = '0; t.e_npr = '0; t.e_rsv = '0;
    t.e_r1 = '0; t.e_r1rdy = '0; t.e_r2 = '0; t.e_r2rdy = '0; t.e_told = '0;
    run_vec("run_squash", t);

    // ---- reset together with squash while halted ----
    run_vec("pre_reset_group", three_addi());
    t = slot0_only(base(3'b111, WFI, addi(2, 0), addi(3, 0)));
    t.e_r1 = {6'd0, 6'd0, 6'd50}; t.e_pr_en = '0;
    t.e_hlt = 3'b001; t.e_halted = 1'b1;
    run_vec("halt_slot0", t);
    t = base(3'b111, addi(1, 0), addi(2, 0), addi(3, 0));
    t.rst = 1'b1; t.sq = 1'b1;
    run_vec("reset_and_squash", t);
    run_vec("post_reset_group", three_addi());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
